// File: rtl/seq_pkg.sv
// Shared constants for the serial pattern generator: FSM state encoding
// and the default transmitted pattern.
package seq_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SHIFT = 3'd1;
    localparam logic [2:0] GAP   = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;

    localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; load has priority over enable.
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_gen_pattern.sv
// Serial pattern transmitter: sends PATTERN MSB-first rep_count times with
// gap_len zero bits between repetitions, then pulses done.
module seq_gen_pattern
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_1011,
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap_len,
    output logic             out_bit,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(PAT_W);
    localparam logic [BW-1:0] BIT_TOP = BW'(PAT_W - 1);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [GAP_W-1:0] gap_lat;
    logic             accept;

    logic             bit_load, bit_en, bit_zero;
    logic [BW-1:0]    bit_idx;
    logic             rep_load, rep_en, rep_zero;
    logic [CNT_W-1:0] rep_left_unused;
    logic             gap_load, gap_en, gap_zero;
    logic [GAP_W-1:0] gap_left_unused;

    assign accept = (state == IDLE) && start && (rep_count != '0);

    // Repetition and gap counters hold "remaining minus one", so their
    // zero flag marks the last repetition / last gap cycle directly.
    seq_down_counter #(.W(BW)) u_bit_cnt (
        .clk(clk), .reset(reset), .load(bit_load), .en(bit_en),
        .load_val(BIT_TOP), .count(bit_idx), .zero(bit_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_rep_cnt (
        .clk(clk), .reset(reset), .load(rep_load), .en(rep_en),
        .load_val(rep_count - 1'b1), .count(rep_left_unused), .zero(rep_zero)
    );

    seq_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk(clk), .reset(reset), .load(gap_load), .en(gap_en),
        .load_val(gap_lat - 1'b1), .count(gap_left_unused), .zero(gap_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            gap_lat <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                gap_lat <= gap_len;
            end
        end
    end

    always_comb begin
        next_state = state;
        bit_load   = 1'b0;
        bit_en     = 1'b0;
        rep_load   = 1'b0;
        rep_en     = 1'b0;
        gap_load   = 1'b0;
        gap_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (rep_count != '0) begin
                        next_state = SHIFT;
                        bit_load   = 1'b1;
                        rep_load   = 1'b1;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            SHIFT: begin
                if (!bit_zero) begin
                    bit_en = 1'b1;
                end else if (rep_zero) begin
                    next_state = DONE;
                end else begin
                    rep_en = 1'b1;
                    if (gap_lat != '0) begin
                        next_state = GAP;
                        gap_load   = 1'b1;
                    end else begin
                        bit_load = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_zero) begin
                    next_state = SHIFT;
                    bit_load   = 1'b1;
                end else begin
                    gap_en = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign out_valid   = (state == SHIFT) || (state == GAP);
    assign out_bit     = (state == SHIFT) && PATTERN[bit_idx];
    assign frame_start = (state == SHIFT) && (bit_idx == BIT_TOP);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_seq_gen_pattern.sv
// Self-checking bench: a queue-based model of the output stream checked every
// cycle, plus literal expectations on captured bit streams.
module tb_seq_gen_pattern;

    localparam int PAT_W = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] rep_count;
    logic [3:0] gap_len;
    logic       out_bit, out_valid, frame_start, busy, done;

    int errors = 0;
    int checks = 0;

    seq_gen_pattern dut (
        .clk(clk), .reset(reset), .start(start), .rep_count(rep_count),
        .gap_len(gap_len), .out_bit(out_bit), .out_valid(out_valid),
        .frame_start(frame_start), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic v;
        logic b;
        logic fs;
        logic bsy;
        logic dn;
    } exp_t;

    exp_t       model_q[$];
    logic [3:0] pat = 4'b1011;
    bit         model_idle;
    bit         chk_on = 0;

    // Model: expected per-cycle outputs are queued when a request is accepted
    always @(posedge clk) begin
        if (!reset) begin
            model_q.delete();
        end else begin
            model_idle = (model_q.size() == 0);
            if (!model_idle) void'(model_q.pop_front());
            if (model_idle && start) begin
                for (int r = 0; r < int'(rep_count); r++) begin
                    for (int i = PAT_W - 1; i >= 0; i--)
                        model_q.push_back('{1'b1, pat[i], (i == PAT_W - 1), 1'b1, 1'b0});
                    if (r != int'(rep_count) - 1)
                        for (int g = 0; g < int'(gap_len); g++)
                            model_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
                end
                model_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_on) begin
            exp_t e;
            exp_t g;
            e = (model_q.size() != 0) ? model_q[0] : '0;
            g = '{out_valid, out_bit, frame_start, busy, done};
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL cycle_check t=%0t got v,b,fs,busy,done=%b expected=%b", $time, g, e);
            end
        end
    end

    logic [63:0] cap_bits, cap_fs;
    int          cap_len, cap_done;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            cap_bits = {cap_bits[62:0], out_bit};
            cap_fs   = {cap_fs[62:0], frame_start};
            cap_len++;
        end
        if (done === 1'b1) cap_done++;
    end

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic clear_capture();
        cap_bits = '0;
        cap_fs   = '0;
        cap_len  = 0;
        cap_done = 0;
    endtask

    task automatic apply_stimulus(input int rep, input int gap);
        @(negedge clk);
        start     = 1'b1;
        rep_count = 8'(rep);
        gap_len   = 4'(gap);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check_output("wait_idle_timeout", {63'd0, busy}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; rep_count = '0; gap_len = '0;
        clear_capture();
        repeat (2) @(negedge clk);
        chk_on = 1;
        reset  = 1'b1;
        repeat (10) @(negedge clk);
        check_output("idle_outputs", {59'd0, out_valid, out_bit, frame_start, busy, done}, 64'd0);
        check_output("idle_no_bits", 64'(cap_len), 64'd0);

        clear_capture();
        apply_stimulus(1, 3);
        check_output("first_bit_latency", {61'd0, out_valid, out_bit, frame_start}, 64'b111);
        wait_idle(100);
        check_output("r1_len", 64'(cap_len), 64'd4);
        check_output("r1_bits", cap_bits, 64'b1011);
        check_output("r1_fs", cap_fs, 64'b1000);
        check_output("r1_done", 64'(cap_done), 64'd1);

        clear_capture();
        apply_stimulus(3, 0);
        wait_idle(100);
        check_output("r3_len", 64'(cap_len), 64'd12);
        check_output("r3_bits", cap_bits, 64'b1011_1011_1011);
        check_output("r3_fs", cap_fs, 64'b1000_1000_1000);

        clear_capture();
        apply_stimulus(2, 2);
        wait_idle(100);
        check_output("r2g2_len", 64'(cap_len), 64'd10);
        check_output("r2g2_bits", cap_bits, 64'b1011001011);
        check_output("r2g2_fs", cap_fs, 64'b1000001000);
        check_output("r2g2_patterns", 64'($countones(cap_fs)), 64'd2);

        clear_capture();
        apply_stimulus(0, 5);
        check_output("r0_done_next", {62'd0, busy, done}, 64'b11);
        wait_idle(100);
        check_output("r0_len", 64'(cap_len), 64'd0);
        check_output("r0_done", 64'(cap_done), 64'd1);

        // A second request mid-frame must be ignored
        clear_capture();
        apply_stimulus(3, 1);
        repeat (4) @(negedge clk);
        start = 1'b1; rep_count = 8'd5; gap_len = 4'd7;
        @(negedge clk);
        start = 1'b0; rep_count = 8'd9; gap_len = 4'd9;
        wait_idle(200);
        check_output("mid_start_len", 64'(cap_len), 64'd14);
        check_output("mid_start_bits", cap_bits, 64'b1011_0_1011_0_1011);
        check_output("mid_start_done", 64'(cap_done), 64'd1);

        // Held start re-triggers on the first idle cycle after done
        clear_capture();
        @(negedge clk);
        start = 1'b1; rep_count = 8'd2; gap_len = 4'd0;
        repeat (14) @(negedge clk);
        start = 1'b0;
        wait_idle(100);
        check_output("held_len", 64'(cap_len), 64'd16);
        check_output("held_done", 64'(cap_done), 64'd2);

        // Reset while bit 6 of the frame is on the line
        clear_capture();
        apply_stimulus(3, 0);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_output("reset_abort", {59'd0, out_valid, out_bit, frame_start, busy, done}, 64'd0);
        repeat (5) @(negedge clk);
        check_output("reset_no_done", 64'(cap_done), 64'd0);
        clear_capture();
        apply_stimulus(1, 0);
        wait_idle(100);
        check_output("after_reset_bits", cap_bits, 64'b1011);
        check_output("after_reset_done", 64'(cap_done), 64'd1);

        // Maximum counts must complete without wrap
        clear_capture();
        apply_stimulus(255, 15);
        wait_idle(6000);
        check_output("max_len", 64'(cap_len), 64'd4830);
        check_output("max_done", 64'(cap_done), 64'd1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
